// File: rtl/rv_rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
package rv_rf_wb_arbiter_pkg;

  // Default data-path width.
  localparam int unsigned BusW = 32;

  // Width of an integer register index.
  localparam int unsigned RegIdxW = 5;

  // Number of architectural integer registers.
  localparam int unsigned NumRegs = 32;

  // Write-back requester indices.
  localparam int unsigned WbAlu = 0;
  localparam int unsigned WbLsu = 1;
  localparam int unsigned WbAes = 2;

  // Default number of write-back requesters.
  localparam int unsigned NumWb = 3;

endpackage

// File: rtl/rv_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from ptr, ptr advances past the winner.
module rv_rr_arbiter #(
  parameter int unsigned NReq = 3,
  localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NReq-1:0] req_i,
  output logic [NReq-1:0] gnt_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            found;

  // Scan requesters starting at ptr, modulo NReq; first valid one wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < NReq; k++) begin
      int unsigned cand;
      cand = (32'(ptr_q) + k) % NReq;
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        gnt_idx_o    = cand[IdxW-1:0];
      end
    end
    // No grants while reset is asserted, so nothing transfers.
    if (rst_i) begin
      gnt_o = '0;
    end
  end

  // Advance past the winner on a grant, otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt_o) begin
      ptr_d = (gnt_idx_o == IdxW'(NReq - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rv_rf_wb_arbiter.sv
// Write-back arbiter for the single register-file write port plus busy scoreboard.
module rv_rf_wb_arbiter
  import rv_rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned BusW = rv_rf_wb_arbiter_pkg::BusW,
  parameter int unsigned NReq = NumWb
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NReq-1:0]         req_valid_i,
  output logic [NReq-1:0]         req_ready_o,
  input  logic [NReq*RegIdxW-1:0] req_addr_i,
  input  logic [NReq*BusW-1:0]    req_data_i,
  input  logic                    rsv_valid_i,
  input  logic [RegIdxW-1:0]      rsv_addr_i,
  output logic                    rsv_ready_o,
  output logic [NumRegs-1:0]      busy_o,
  output logic                    rf_we_o,
  output logic [RegIdxW-1:0]      rf_waddr_o,
  output logic [BusW-1:0]         rf_wdata_o
);

  localparam int unsigned IdxW = (NReq > 1) ? $clog2(NReq) : 1;

  logic [IdxW-1:0]    gnt_idx;
  logic               xfer;
  logic [RegIdxW-1:0] sel_addr;
  logic [BusW-1:0]    sel_data;
  logic               clr_hit;

  logic [NumRegs-1:0] busy_q, busy_d;
  logic               rf_we_q, rf_we_d;
  logic [RegIdxW-1:0] rf_waddr_q, rf_waddr_d;
  logic [BusW-1:0]    rf_wdata_q, rf_wdata_d;

  rv_rr_arbiter #(
    .NReq (NReq)
  ) u_rr_arbiter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .gnt_o     (req_ready_o),
    .gnt_idx_o (gnt_idx)
  );

  // Ready is only ever raised for a valid requester, so any grant is a transfer.
  assign xfer = |req_ready_o;

  // Select the winner's address and data.
  always_comb begin
    int unsigned sel;
    sel      = 32'(gnt_idx);
    sel_addr = req_addr_i[sel*RegIdxW +: RegIdxW];
    sel_data = req_data_i[sel*BusW +: BusW];
  end

  // Reservation accept: free, x0, or freed by a write landing this cycle.
  always_comb begin
    clr_hit     = xfer && (sel_addr == rsv_addr_i);
    rsv_ready_o = !rst_i && rsv_valid_i &&
                  ((rsv_addr_i == '0) || !busy_q[rsv_addr_i] || clr_hit);
  end

  // Scoreboard next state: clear on write-back, then set on reservation so set wins.
  always_comb begin
    busy_d = busy_q;
    if (xfer && (sel_addr != '0)) begin
      busy_d[sel_addr] = 1'b0;
    end
    if (rsv_ready_o && (rsv_addr_i != '0)) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Output register next state; x0 writes load the address/data but never enable.
  always_comb begin
    rf_we_d    = xfer && (sel_addr != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer) begin
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign busy_o     = busy_q;
  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

endmodule
